// File: rtl/pair_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pair_pack_pkg
// Description : Shared widths, FSM state encoding and data types for the
//               byte-pair packing arbiter and its bench.
// Revision    : 1.0 - initial release
// ============================================================================
package pair_pack_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    SEND  = 2'd3
  } pp_state_e;

  typedef logic [BYTE_W-1:0] byte_t;
  typedef logic [WORD_W-1:0] word_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Returns the lowest index at
//               or after (last_i+1) mod NUM_REQ whose valid bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   winner_o
);

  logic [IDX_W-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest valid one wins.
  always_comb begin
    any_o    = |valid_i;
    winner_o = '0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
      if (valid_i[cand]) begin
        winner_o = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/byte_pair_pack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : byte_pair_pack_arbiter
// Description : Round-robin shares one byte-pair packer among NUM_REQ byte
//               requesters; two bytes from the granted requester form one
//               16-bit word. A stalled second byte aborts the partial word.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_pair_pack_arbiter
  import pair_pack_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 16,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*8-1:0]  req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  out_valid,
  output logic [WORD_W-1:0]     out_data,
  output logic [IDX_W-1:0]      out_src,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  err_abort
);

  localparam int               CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  pp_state_e         state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  byte_t             buf1_q, buf1_d;
  byte_t             buf2_q, buf2_d;
  logic              err_abort_q, err_abort_d;

  byte_t             req_bytes [NUM_REQ];
  byte_t             cur_byte;
  logic              rr_any;
  logic [IDX_W-1:0]  rr_winner;
  logic [IDX_W-1:0]  rr_last;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
  end

  assign cur_byte = req_bytes[grant_q];

  // Re-arbitration out of SEND happens in the same cycle last_grant takes the
  // current grant, so the picker sees the grant directly in that state.
  assign rr_last = (state_q == SEND) ? grant_q : last_grant_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid_i  (req_valid),
    .last_i   (rr_last),
    .any_o    (rr_any),
    .winner_o (rr_winner)
  );

  // State and datapath registers; reset drops any partial word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      wait_cnt_q   <= '0;
      buf1_q       <= '0;
      buf2_q       <= '0;
      err_abort_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      buf1_q       <= buf1_d;
      buf2_q       <= buf2_d;
      err_abort_q  <= err_abort_d;
    end
  end

  // Next-state: arbitrate, collect two bytes, present the word, time out.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wait_cnt_d   = wait_cnt_q;
    buf1_d       = buf1_q;
    buf2_d       = buf2_q;
    err_abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rr_any) begin
          grant_d = rr_winner;
          state_d = BYTE0;
        end
      end
      BYTE0: begin
        if (req_valid[grant_q]) begin
          buf1_d     = cur_byte;
          wait_cnt_d = '0;
          state_d    = BYTE1;
        end
      end
      BYTE1: begin
        if (req_valid[grant_q]) begin
          buf2_d     = cur_byte;
          wait_cnt_d = '0;
          state_d    = SEND;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          err_abort_d  = 1'b1;
          buf1_d       = '0;
          wait_cnt_d   = '0;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      SEND: begin
        if (out_ready) begin
          last_grant_d = grant_q;
          if (rr_any) begin
            grant_d = rr_winner;
            state_d = BYTE0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready is decoded from registered state and grant only.
  always_comb begin
    req_ready = '0;
    if ((state_q == BYTE0) || (state_q == BYTE1)) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign out_valid = (state_q == SEND);
  assign out_data  = {buf1_q, buf2_q};
  assign out_src   = grant_q;
  assign busy      = (state_q != IDLE);
  assign err_abort = err_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_byte_pair_pack_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_byte_pair_pack_arbiter
// Description : Directed and randomized bench for byte_pair_pack_arbiter,
//               checked cycle by cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_byte_pair_pack_arbiter;
  import pair_pack_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*8-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  word_t           out_data;
  logic [IW-1:0]   out_src;
  logic            out_ready;
  logic            busy;
  logic            err_abort;

  always #5 clk = ~clk;

  byte_pair_pack_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy),
    .err_abort (err_abort)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: who owns the pipeline, how many bytes it holds,
  // how long it has stalled, and who was served last.
  int    m_owner;
  int    m_have;
  int    m_stall;
  int    m_last;
  bit    m_err;
  byte_t m_b1, m_b2;

  function automatic int rr(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N*8-1:0] put(input int slot, input byte_t b);
    logic [N*8-1:0] d;
    d = '0;
    d[slot*8 +: 8] = b;
    return d;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_have = 0; m_stall = 0; m_last = N - 1; m_err = 1'b0;
    m_b1 = '0; m_b2 = '0;
  endtask

  task automatic model_step(input logic [N-1:0] v, input logic [N*8-1:0] d, input logic r);
    m_err = 1'b0;
    if (m_owner < 0) begin
      if (v != '0) begin
        m_owner = rr(v, m_last); m_have = 0; m_stall = 0;
      end
    end else if (m_have == 0) begin
      if (v[m_owner]) begin
        m_b1 = d[m_owner*8 +: 8]; m_have = 1; m_stall = 0;
      end
    end else if (m_have == 1) begin
      if (v[m_owner]) begin
        m_b2 = d[m_owner*8 +: 8]; m_have = 2;
      end else if (m_stall == TO) begin
        m_err = 1'b1; m_last = m_owner; m_owner = -1; m_have = 0;
      end else begin
        m_stall++;
      end
    end else if (r) begin
      m_last = m_owner;
      m_have = 0;
      m_owner = (v != '0) ? rr(v, m_last) : -1;
      m_stall = 0;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] e_rdy;
    e_rdy = '0;
    if (m_owner >= 0 && m_have < 2) e_rdy = N'(1) << m_owner;
    check_eq("req_ready", 32'(req_ready), 32'(e_rdy));
    check_eq("busy",      32'(busy),      32'(m_owner >= 0));
    check_eq("out_valid", 32'(out_valid), 32'(m_owner >= 0 && m_have == 2));
    check_eq("err_abort", 32'(err_abort), 32'(m_err));
    if (m_owner >= 0 && m_have == 2) begin
      check_eq("out_data", 32'(out_data), 32'({m_b1, m_b2}));
      check_eq("out_src",  32'(out_src),  32'(m_owner));
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, compare after.
  task automatic cycle(input logic [N-1:0] v, input logic [N*8-1:0] d, input logic r);
    req_valid = v; req_data = d; out_ready = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; out_ready = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int srcs[$];
  int tims[$];
  int n_err, n_ov;

  initial begin
    rst_n = 1'b0;
    req_valid = '0; req_data = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy",      32'(busy),      32'(0));
    check_eq("rst_out_valid", 32'(out_valid), 32'(0));
    check_eq("rst_req_ready", 32'(req_ready), 32'(0));
    check_eq("rst_out_data",  32'(out_data),  32'(16'h0000));
    check_eq("rst_out_src",   32'(out_src),   32'(0));
    check_eq("rst_err_abort", 32'(err_abort), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester, minimum latency.
    cycle(4'b0100, put(2, 8'hA5), 1'b1);
    check_eq("single_ready", 32'(req_ready), 32'(4'b0100));
    cycle(4'b0100, put(2, 8'hA5), 1'b1);
    cycle(4'b0100, put(2, 8'h3C), 1'b1);
    check_eq("single_valid", 32'(out_valid), 32'(1));
    check_eq("single_data",  32'(out_data),  32'(16'hA53C));
    check_eq("single_src",   32'(out_src),   32'(2));
    cycle(4'b0000, '0, 1'b1);
    check_eq("single_busy_fall", 32'(busy), 32'(0));

    // All requesters valid: strict rotation, one word per 3 cycles.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(4'b1111, 32'($urandom), 1'b1);
      if (out_valid) begin
        srcs.push_back(int'(out_src));
        tims.push_back(cyc);
      end
    end
    check_eq("rot_nwords", 32'(srcs.size()), 32'(5));
    if (srcs.size() == 5) begin
      check_eq("rot_src0", 32'(srcs[0]), 32'(0));
      check_eq("rot_src1", 32'(srcs[1]), 32'(1));
      check_eq("rot_src2", 32'(srcs[2]), 32'(2));
      check_eq("rot_src3", 32'(srcs[3]), 32'(3));
      check_eq("rot_src4", 32'(srcs[4]), 32'(0));
      for (int i = 1; i < 5; i++) check_eq("rot_gap", 32'(tims[i] - tims[i-1]), 32'(3));
    end

    // Consumer stall for 5 cycles, delivery on the 6th.
    do_reset();
    cycle(4'b0001, put(0, 8'h5A), 1'b0);
    cycle(4'b0001, put(0, 8'h5A), 1'b0);
    cycle(4'b0001, put(0, 8'hC3), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000, '0, 1'b0);
      check_eq("stall_data",  32'(out_data),  32'(16'h5AC3));
      check_eq("stall_src",   32'(out_src),   32'(0));
      check_eq("stall_ready", 32'(req_ready), 32'(0));
      check_eq("stall_valid", 32'(out_valid), 32'(1));
    end
    cycle(4'b0000, '0, 1'b1);
    check_eq("stall_done", 32'(busy), 32'(0));

    // Timeout on the second byte, then rotation moves on to requester 2.
    do_reset();
    cycle(4'b0010, put(1, 8'h11), 1'b1);
    cycle(4'b0010, put(1, 8'h11), 1'b1);
    n_err = 0; n_ov = 0;
    for (int i = 0; i < 17; i++) begin
      cycle(4'b0000, '0, 1'b1);
      n_err += int'(err_abort);
      n_ov  += int'(out_valid);
    end
    check_eq("to_err_last", 32'(err_abort), 32'(1));
    check_eq("to_busy",     32'(busy),      32'(0));
    check_eq("to_err_cnt",  32'(n_err),     32'(1));
    check_eq("to_no_word",  32'(n_ov),      32'(0));
    cycle(4'b0110, put(1, 8'h22) | put(2, 8'h33), 1'b1);
    check_eq("to_next_grant", 32'(req_ready), 32'(4'b0100));
    cycle(4'b0110, put(2, 8'h33), 1'b1);
    cycle(4'b0110, put(2, 8'h44), 1'b1);
    check_eq("to_next_data", 32'(out_data), 32'(16'h3344));
    cycle(4'b0000, '0, 1'b1);

    // Asynchronous reset while holding first byte 8'hFF.
    do_reset();
    cycle(4'b0001, put(0, 8'hFF), 1'b1);
    cycle(4'b0001, put(0, 8'hFF), 1'b1);
    check_eq("ar_in_byte1", 32'(req_ready), 32'(4'b0001));
    #2;
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    model_reset();
    check_eq("ar_busy",      32'(busy),      32'(0));
    check_eq("ar_out_valid", 32'(out_valid), 32'(0));
    check_eq("ar_out_data",  32'(out_data),  32'(16'h0000));
    check_eq("ar_req_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1001, put(0, 8'h01) | put(3, 8'h03), 1'b1);
    check_eq("ar_first_win", 32'(req_ready), 32'(4'b0001));
    cycle(4'b0001, put(0, 8'h01), 1'b1);
    cycle(4'b0001, put(0, 8'h02), 1'b1);
    cycle(4'b0000, '0, 1'b1);

    // Wrap-around: serve requester 3, then 0 and 3 both valid -> 0.
    cycle(4'b1000, put(3, 8'h31), 1'b1);
    check_eq("wrap_grant3", 32'(req_ready), 32'(4'b1000));
    cycle(4'b1000, put(3, 8'h31), 1'b1);
    cycle(4'b1000, put(3, 8'h32), 1'b1);
    cycle(4'b1001, put(0, 8'h0A) | put(3, 8'h3A), 1'b1);
    check_eq("wrap_grant0", 32'(req_ready), 32'(4'b0001));

    // Randomized traffic with occasional quiet stretches to hit timeouts.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] v;
      if ((i % 150) >= 130) begin
        v = '0;
      end else begin
        for (int b = 0; b < N; b++) v[b] = ($urandom_range(0, 9) < 6);
      end
      cycle(v, 32'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
